// File: rtl/image_bank_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// image_bank_ctrl_pkg
// Shared constants and state types for the ping-pong image bank controller.
//   IMG_BITS : bits per image (multiple of BYTE_W)
//   BYTE_W   : bits per received byte
//   ADDR_W   : in-bank address width (RAM address is {bank, addr})
//   CNT_W    : width of the per-byte bit counter
// ---------------------------------------------------------------------------
package image_bank_ctrl_pkg;

  localparam int IMG_BITS = 784;
  localparam int BYTE_W   = 8;
  localparam int ADDR_W   = 10;
  localparam int CNT_W    = $clog2(BYTE_W);

  typedef enum logic {L_IDLE, L_WRITE} load_state_t;
  typedef enum logic {R_IDLE, R_BUSY}  run_state_t;

endpackage

// File: rtl/image_bank_ctrl_if.sv
// ---------------------------------------------------------------------------
// image_bank_ctrl_if
// Bundles the byte-loader stream, the snn_core handshake and the single RAM
// port driven by the controller.
//   slave  : controller side (consumes bytes/core requests, drives RAM port)
//   master : environment side (UART loader, snn_core, RAM)
// ---------------------------------------------------------------------------
interface image_bank_ctrl_if;
  import image_bank_ctrl_pkg::*;

  logic [BYTE_W-1:0] byte_in;
  logic              byte_vld;
  logic              byte_rdy;
  logic              core_rd_req;
  logic [ADDR_W-1:0] core_addr;
  logic              core_done;
  logic              core_start;
  logic [ADDR_W:0]   ram_addr;
  logic              ram_we;
  logic              ram_d;
  logic              img_done;
  logic [1:0]        bank_full;

  modport slave (
    input  byte_in, byte_vld, core_rd_req, core_addr, core_done,
    output byte_rdy, core_start, ram_addr, ram_we, ram_d, img_done, bank_full
  );

  modport master (
    output byte_in, byte_vld, core_rd_req, core_addr, core_done,
    input  byte_rdy, core_start, ram_addr, ram_we, ram_d, img_done, bank_full
  );

endinterface

// File: rtl/image_bank_ctrl_byte_serializer.sv
// ---------------------------------------------------------------------------
// image_bank_ctrl_byte_serializer
// Holds one received byte and presents it LSB-first, one bit per granted
// RAM write.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush
//   load       : capture din and restart the bit count
//   din        : byte to serialize
//   advance    : current bit was written; shift to the next one
//   bit_out    : bit currently offered to the RAM
//   last_bit   : bit_out is the final bit of the byte
// ---------------------------------------------------------------------------
module image_bank_ctrl_byte_serializer
  import image_bank_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [BYTE_W-1:0] din,
  input  logic              advance,
  output logic              bit_out,
  output logic              last_bit
);

  logic [BYTE_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= din;
      bit_cnt <= '0;
    end else if (advance) begin
      shreg   <= shreg >> 1;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign bit_out  = shreg[0];
  assign last_bit = (bit_cnt == CNT_W'(BYTE_W - 1));

endmodule

// File: rtl/image_bank_ctrl.sv
// ---------------------------------------------------------------------------
// image_bank_ctrl
// Ping-pong scheduler for the 2-bank single-port input image RAM. Received
// bytes are serialized into the fill bank while snn_core classifies the
// other bank; core reads always win the RAM port.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous flush of both banks, load and run
//   bus   : byte stream, snn_core handshake, RAM port and bank flags
// ---------------------------------------------------------------------------
module image_bank_ctrl
  import image_bank_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  image_bank_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] IMG_LAST = ADDR_W'(IMG_BITS - 1);

  load_state_t       l_state, l_state_nxt;
  run_state_t        r_state;
  logic              fill_bank, fill_bank_nxt;
  logic              run_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        bank_full, bank_full_nxt;
  logic              byte_rdy_q, core_start_q, img_done_q;
  logic              accept, grant, img_end, release_bank;
  logic              ser_bit, last_bit;

  assign accept       = (l_state == L_IDLE) && bus.byte_vld && byte_rdy_q;
  assign grant        = (l_state == L_WRITE) && !bus.core_rd_req;
  assign img_end      = grant && (wr_addr == IMG_LAST);
  assign release_bank = (r_state == R_BUSY) && bus.core_done;

  image_bank_ctrl_byte_serializer u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (accept),
    .din      (bus.byte_in),
    .advance  (grant),
    .bit_out  (ser_bit),
    .last_bit (last_bit)
  );

  // A load finishing and a core release can land in the same cycle; they
  // always target different banks, so both updates are applied.
  always_comb begin
    bank_full_nxt = bank_full;
    if (release_bank) bank_full_nxt[run_bank] = 1'b0;
    if (img_end)      bank_full_nxt[fill_bank] = 1'b1;
  end

  always_comb begin
    l_state_nxt = l_state;
    if (accept)                l_state_nxt = L_WRITE;
    else if (grant && last_bit) l_state_nxt = L_IDLE;
  end

  assign fill_bank_nxt = fill_bank ^ img_end;

  // Load FSM plus bank flags. byte_rdy is registered from next-state values
  // so it follows the idle/full rule without a combinational path, and stays
  // low for the first cycle after reset or clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_state    <= L_IDLE;
      byte_rdy_q <= 1'b0;
      wr_addr    <= '0;
      fill_bank  <= 1'b0;
      bank_full  <= 2'b00;
    end else if (clr) begin
      l_state    <= L_IDLE;
      byte_rdy_q <= 1'b0;
      wr_addr    <= '0;
      fill_bank  <= 1'b0;
      bank_full  <= 2'b00;
    end else begin
      l_state    <= l_state_nxt;
      byte_rdy_q <= (l_state_nxt == L_IDLE) && !bank_full_nxt[fill_bank_nxt];
      fill_bank  <= fill_bank_nxt;
      bank_full  <= bank_full_nxt;
      if (grant) wr_addr <= img_end ? '0 : wr_addr + 1'b1;
    end
  end

  // Run FSM: start the core on a full run bank, release it on core_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= R_IDLE;
      run_bank     <= 1'b0;
      core_start_q <= 1'b0;
      img_done_q   <= 1'b0;
    end else if (clr) begin
      r_state      <= R_IDLE;
      run_bank     <= 1'b0;
      core_start_q <= 1'b0;
      img_done_q   <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      img_done_q   <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (bank_full[run_bank]) begin
            core_start_q <= 1'b1;
            r_state      <= R_BUSY;
          end
        end
        R_BUSY: begin
          if (bus.core_done) begin
            run_bank   <= ~run_bank;
            img_done_q <= 1'b1;
            r_state    <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Core reads own the port outright; otherwise the loader address is shown
  // even when no write is granted.
  assign bus.ram_addr   = bus.core_rd_req ? {run_bank, bus.core_addr} : {fill_bank, wr_addr};
  assign bus.ram_we     = grant;
  assign bus.ram_d      = grant & ser_bit;
  assign bus.byte_rdy   = byte_rdy_q;
  assign bus.core_start = core_start_q;
  assign bus.img_done   = img_done_q;
  assign bus.bank_full  = bank_full;

endmodule
